// File: rtl/max7219_chain_ctrl.sv
// max7219_chain_ctrl: frame-buffered driver for a daisy chain of MAX7219 LED drivers,
// with built-in SPI serializer, power-up init sequence, refresh and intensity commands.
`default_nettype none

module max7219_chain_ctrl #(
    parameter int          NUM_DEV    = 1,
    parameter int          CLK_DIV    = 4,
    parameter logic [7:0]  DECODE     = 8'h00,
    parameter logic [2:0]  SCAN_LIMIT = 3'd7,
    localparam int         DW         = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_dev,
    input  logic [2:0]    wr_digit,
    input  logic [7:0]    wr_data,
    input  logic          update,
    input  logic [3:0]    intensity,
    input  logic          set_int,
    output logic          busy,
    output logic          init_done,
    output logic          sck,
    output logic          dout,
    output logic          cs
);

    localparam int NB = 16 * NUM_DEV;
    localparam int BW = $clog2(NB);
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [BW-1:0] LAST_BIT = BW'(NB - 1);
    localparam logic [CW-1:0] CD_END   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(2 * CLK_DIV - 1);
    localparam logic [DW:0]   DEV_CNT  = (DW + 1)'(NUM_DEV);

    typedef enum logic [1:0] {T_INIT, T_IDLE, T_REFRESH, T_INTENS} top_t;
    typedef enum logic [2:0] {S_LOAD, S_LOW, S_HIGH, S_TAIL, S_GAP} ser_t;

    top_t                           top_q, top_d;
    ser_t                           ser_q, ser_d;
    logic [3:0]                     step_q, step_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [BW-1:0]                  bit_q, bit_d;
    logic [NB-1:0]                  shift_q, shift_d;
    logic [NUM_DEV-1:0][7:0][7:0]   fb_q, fb_d;
    logic                           upd_pend_q, upd_pend_d;
    logic                           int_pend_q, int_pend_d;
    logic                           init_done_q, init_done_d;
    logic                           busy_q, busy_d;
    logic                           cs_q, cs_d;
    logic                           sck_q, sck_d;
    logic                           dout_q, dout_d;

    logic [NB-1:0] frame;
    logic [7:0]    cfg_addr, cfg_data;
    logic [2:0]    dig;
    logic          use_fb;
    logic          frame_done;

    // Frame contents: every device gets the same register address; device 0 sits in the LSBs
    // so it is shifted last and ends up in the device nearest dout.
    always_comb begin
        cfg_addr = 8'h00;
        cfg_data = 8'h00;
        dig      = step_q[2:0];
        use_fb   = 1'b0;
        frame    = '0;
        case (top_q)
            T_INIT: begin
                case (step_q)
                    4'd0:    begin cfg_addr = 8'h0C; cfg_data = 8'h00;                end
                    4'd1:    begin cfg_addr = 8'h0F; cfg_data = 8'h00;                end
                    4'd2:    begin cfg_addr = 8'h09; cfg_data = DECODE;               end
                    4'd3:    begin cfg_addr = 8'h0B; cfg_data = {5'b0, SCAN_LIMIT};   end
                    4'd4:    begin cfg_addr = 8'h0A; cfg_data = {4'h0, intensity};    end
                    4'd5:    begin cfg_addr = 8'h0C; cfg_data = 8'h01;                end
                    default: begin use_fb = 1'b1; dig = 3'(step_q - 4'd6);           end
                endcase
            end
            T_REFRESH: use_fb = 1'b1;
            T_INTENS:  begin cfg_addr = 8'h0A; cfg_data = {4'h0, intensity}; end
            default:   ;
        endcase
        for (int d = 0; d < NUM_DEV; d++) begin
            frame[16*d +: 16] = use_fb ? {{5'b0, dig} + 8'd1, fb_q[d][dig]} : {cfg_addr, cfg_data};
        end
    end

    always_comb begin
        top_d       = top_q;
        ser_d       = ser_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        fb_d        = fb_q;
        upd_pend_d  = upd_pend_q | update;
        int_pend_d  = int_pend_q | set_int;
        init_done_d = init_done_q;
        cs_d        = cs_q;
        sck_d       = sck_q;
        dout_d      = dout_q;
        frame_done  = 1'b0;

        if (wr_en && ({1'b0, wr_dev} < DEV_CNT)) begin
            fb_d[wr_dev][wr_digit] = wr_data;
        end

        if (top_q == T_IDLE) begin
            ser_d  = S_LOAD;
            step_d = 4'd0;
            if (update || upd_pend_q) begin
                top_d      = T_REFRESH;
                upd_pend_d = 1'b0;
            end else if (set_int || int_pend_q) begin
                top_d      = T_INTENS;
                int_pend_d = 1'b0;
            end
        end else begin
            case (ser_q)
                S_LOAD: begin
                    shift_d = {frame[NB-2:0], 1'b0};
                    dout_d  = frame[NB-1];
                    cs_d    = 1'b0;
                    sck_d   = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    ser_d   = S_LOW;
                end
                S_LOW: begin
                    if (cnt_q == CD_END) begin
                        cnt_d = '0;
                        sck_d = 1'b1;
                        ser_d = S_HIGH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (cnt_q == CD_END) begin
                        cnt_d = '0;
                        sck_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            dout_d = 1'b0;
                            ser_d  = S_TAIL;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            dout_d  = shift_q[NB-1];
                            shift_d = {shift_q[NB-2:0], 1'b0};
                            ser_d   = S_LOW;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_TAIL: begin
                    if (cnt_q == CD_END) begin
                        cnt_d = '0;
                        cs_d  = 1'b1;
                        ser_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_END) begin
                        cnt_d      = '0;
                        ser_d      = S_LOAD;
                        frame_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ser_d = S_LOAD;
            endcase

            if (frame_done) begin
                case (top_q)
                    T_INIT: begin
                        if (step_q == 4'd13) begin
                            top_d       = T_IDLE;
                            step_d      = 4'd0;
                            init_done_d = 1'b1;
                        end else begin
                            step_d = step_q + 4'd1;
                        end
                    end
                    T_REFRESH: begin
                        if (step_q == 4'd7) begin
                            top_d  = T_IDLE;
                            step_d = 4'd0;
                        end else begin
                            step_d = step_q + 4'd1;
                        end
                    end
                    default: top_d = T_IDLE;
                endcase
            end
        end

        busy_d = (top_d != T_IDLE) || upd_pend_d || int_pend_d;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            top_q       <= T_INIT;
            ser_q       <= S_LOAD;
            step_q      <= 4'd0;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            fb_q        <= '0;
            upd_pend_q  <= 1'b0;
            int_pend_q  <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            cs_q        <= 1'b1;
            sck_q       <= 1'b0;
            dout_q      <= 1'b0;
        end else begin
            top_q       <= top_d;
            ser_q       <= ser_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            fb_q        <= fb_d;
            upd_pend_q  <= upd_pend_d;
            int_pend_q  <= int_pend_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            cs_q        <= cs_d;
            sck_q       <= sck_d;
            dout_q      <= dout_d;
        end
    end

    assign busy      = busy_q;
    assign init_done = init_done_q;
    assign cs        = cs_q;
    assign sck       = sck_q;
    assign dout      = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_max7219_chain_ctrl.sv
// tb_max7219_chain_ctrl: directed bench for a 2-device chain (CLK_DIV=2) and a 3-device chain (CLK_DIV=1).
`default_nettype none

module tb_max7219_chain_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst_a, wr_en_a, update_a, set_int_a;
    logic [0:0] wr_dev_a;
    logic [2:0] wr_digit_a;
    logic [7:0] wr_data_a;
    logic [3:0] int_a;
    logic       busy_a, init_done_a, sck_a, dout_a, cs_a;

    logic       rst_b, wr_en_b, update_b, set_int_b;
    logic [1:0] wr_dev_b;
    logic [2:0] wr_digit_b;
    logic [7:0] wr_data_b;
    logic [3:0] int_b;
    logic       busy_b, init_done_b, sck_b, dout_b, cs_b;

    max7219_chain_ctrl #(.NUM_DEV(2), .CLK_DIV(2)) u_a (
        .CLK(CLK), .rst(rst_a), .wr_en(wr_en_a), .wr_dev(wr_dev_a), .wr_digit(wr_digit_a),
        .wr_data(wr_data_a), .update(update_a), .intensity(int_a), .set_int(set_int_a),
        .busy(busy_a), .init_done(init_done_a), .sck(sck_a), .dout(dout_a), .cs(cs_a)
    );

    max7219_chain_ctrl #(.NUM_DEV(3), .CLK_DIV(1)) u_b (
        .CLK(CLK), .rst(rst_b), .wr_en(wr_en_b), .wr_dev(wr_dev_b), .wr_digit(wr_digit_b),
        .wr_data(wr_data_b), .update(update_b), .intensity(int_b), .set_int(set_int_b),
        .busy(busy_b), .init_done(init_done_b), .sck(sck_b), .dout(dout_b), .cs(cs_b)
    );

    // Frame capture: bits taken on sck rising edges while cs is low, pushed when cs rises.
    logic [47:0] fa[$];
    int          la[$];
    logic [47:0] fb[$];
    logic [47:0] acc_a, acc_b;
    int          low_a, low_b;
    logic        pcs_a, psck_a, pcs_b, psck_b;

    always @(negedge CLK) begin
        if (pcs_a === 1'b1 && cs_a === 1'b0) begin acc_a = '0; low_a = 0; end
        if (cs_a === 1'b0) low_a++;
        if (sck_a === 1'b1 && psck_a === 1'b0 && cs_a === 1'b0) acc_a = {acc_a[46:0], dout_a};
        if (pcs_a === 1'b0 && cs_a === 1'b1) begin fa.push_back(acc_a); la.push_back(low_a); end
        pcs_a  = cs_a;
        psck_a = sck_a;
        if (pcs_b === 1'b1 && cs_b === 1'b0) begin acc_b = '0; low_b = 0; end
        if (cs_b === 1'b0) low_b++;
        if (sck_b === 1'b1 && psck_b === 1'b0 && cs_b === 1'b0) acc_b = {acc_b[46:0], dout_b};
        if (pcs_b === 1'b0 && cs_b === 1'b1) fb.push_back(acc_b);
        pcs_b  = cs_b;
        psck_b = sck_b;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; wr_en_a = 1'b0; update_a = 1'b0; set_int_a = 1'b0;
        wr_dev_a = '0; wr_digit_a = '0; wr_data_a = '0; int_a = 4'h0;
        rst_b = 1'b1; wr_en_b = 1'b0; update_b = 1'b0; set_int_b = 1'b0;
        wr_dev_b = '0; wr_digit_b = '0; wr_data_b = '0; int_b = 4'h0;
        acc_a = '0; acc_b = '0; low_a = 0; low_b = 0;
        pcs_a = 1'b1; psck_a = 1'b0; pcs_b = 1'b1; psck_b = 1'b0;

        repeat (3) tick();
        chk("rst_cs",        48'(cs_a),        48'd1);
        chk("rst_sck",       48'(sck_a),       48'd0);
        chk("rst_dout",      48'(dout_a),      48'd0);
        chk("rst_busy",      48'(busy_a),      48'd1);
        chk("rst_init_done", 48'(init_done_a), 48'd0);

        // Power-up init of the 2-device chain
        fa.delete(); la.delete();
        rst_a = 1'b0;
        for (int i = 0; i < 4000 && init_done_a !== 1'b1; i++) tick();
        chk("init_done",   48'(init_done_a), 48'd1);
        chk("init_busy",   48'(busy_a),      48'd0);
        chk("init_frames", 48'(fa.size()),   48'd14);
        if (fa.size() >= 14) begin
            chk("init_f0",    fa[0],         48'h0C00_0C00);
            chk("init_cslow", 48'(la[0]),    48'd130);
            chk("init_f1",    fa[1],         48'h0F00_0F00);
            chk("init_f2",    fa[2],         48'h0900_0900);
            chk("init_f3",    fa[3],         48'h0B07_0B07);
            chk("init_f4",    fa[4],         48'h0A00_0A00);
            chk("init_f5",    fa[5],         48'h0C01_0C01);
            chk("init_f6",    fa[6],         48'h0100_0100);
            chk("init_f13",   fa[13],        48'h0800_0800);
        end

        // Buffer writes then refresh; cs must fall two edges after update
        wr_en_a = 1'b1; wr_dev_a = 1'b1; wr_digit_a = 3'd3; wr_data_a = 8'h4F;
        tick();
        wr_dev_a = 1'b0; wr_data_a = 8'h3D;
        tick();
        wr_en_a = 1'b0;
        fa.delete(); la.delete();
        update_a = 1'b1;
        tick();
        update_a = 1'b0;
        chk("upd_cs_high", 48'(cs_a), 48'd1);
        tick();
        chk("upd_cs_fall", 48'(cs_a), 48'd0);
        for (int i = 0; i < 3000 && busy_a !== 1'b0; i++) tick();
        chk("ref_busy",   48'(busy_a),    48'd0);
        chk("ref_frames", 48'(fa.size()), 48'd8);
        if (fa.size() >= 8) begin
            chk("ref_f0", fa[0], 48'h0100_0100);
            chk("ref_f3", fa[3], 48'h044F_043D);
            chk("ref_f7", fa[7], 48'h0800_0800);
        end

        // Update during the second frame of a refresh -> one extra full refresh
        fa.delete(); la.delete();
        update_a = 1'b1;
        tick();
        update_a = 1'b0;
        for (int i = 0; i < 400 && fa.size() < 1; i++) tick();
        repeat (20) tick();
        update_a = 1'b1;
        tick();
        update_a = 1'b0;
        for (int i = 0; i < 5000 && busy_a !== 1'b0; i++) tick();
        chk("dbl_busy",   48'(busy_a),    48'd0);
        chk("dbl_frames", 48'(fa.size()), 48'd16);
        if (fa.size() >= 16) begin
            chk("dbl_f8",  fa[8],  48'h0100_0100);
            chk("dbl_f11", fa[11], 48'h044F_043D);
        end

        // Intensity command
        fa.delete(); la.delete();
        int_a = 4'hA;
        set_int_a = 1'b1;
        tick();
        set_int_a = 1'b0;
        for (int i = 0; i < 1000 && busy_a !== 1'b0; i++) tick();
        chk("int_busy",   48'(busy_a),    48'd0);
        chk("int_frames", 48'(fa.size()), 48'd1);
        if (fa.size() >= 1) chk("int_f0", fa[0], 48'h0A0A_0A0A);

        // Reset pulse in the middle of a frame
        update_a = 1'b1;
        tick();
        update_a = 1'b0;
        repeat (30) tick();
        chk("mid_cs_low", 48'(cs_a), 48'd0);
        rst_a = 1'b1;
        tick();
        chk("mid_rst_cs",   48'(cs_a),        48'd1);
        chk("mid_rst_sck",  48'(sck_a),       48'd0);
        chk("mid_rst_init", 48'(init_done_a), 48'd0);
        rst_a = 1'b0;
        fa.delete(); la.delete();
        for (int i = 0; i < 4000 && init_done_a !== 1'b1; i++) tick();
        chk("reinit_done",   48'(init_done_a), 48'd1);
        chk("reinit_frames", 48'(fa.size()),   48'd14);
        if (fa.size() >= 14) begin
            chk("reinit_f0", fa[0], 48'h0C00_0C00);
            chk("reinit_f4", fa[4], 48'h0A0A_0A0A);
            chk("reinit_f9", fa[9], 48'h0400_0400);
        end

        // 3-device chain: out-of-range device write is ignored
        fb.delete();
        rst_b = 1'b0;
        for (int i = 0; i < 3000 && init_done_b !== 1'b1; i++) tick();
        chk("b_init_done",   48'(init_done_b), 48'd1);
        chk("b_init_frames", 48'(fb.size()),   48'd14);
        if (fb.size() >= 1) chk("b_init_f0", fb[0], 48'h0C00_0C00_0C00);
        wr_en_b = 1'b1; wr_dev_b = 2'd3; wr_digit_b = 3'd2; wr_data_b = 8'hFF;
        tick();
        wr_dev_b = 2'd2; wr_digit_b = 3'd0; wr_data_b = 8'h5A;
        tick();
        wr_en_b = 1'b0;
        fb.delete();
        update_b = 1'b1;
        tick();
        update_b = 1'b0;
        for (int i = 0; i < 3000 && busy_b !== 1'b0; i++) tick();
        chk("b_ref_busy",   48'(busy_b),    48'd0);
        chk("b_ref_frames", 48'(fb.size()), 48'd8);
        if (fb.size() >= 8) begin
            chk("b_ref_f0", fb[0], 48'h015A_0100_0100);
            chk("b_ref_f2", fb[2], 48'h0300_0300_0300);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/max7219_chain_ctrl.md
# max7219_chain_ctrl

Parametrised driver for NUM_DEV daisy-chained MAX7219 8-digit LED drivers. It contains its own SPI serializer, a frame buffer of NUM_DEV×8 digit bytes, an automatic power-up init sequence, and on-demand refresh and intensity commands. It sits between display-producing logic in top-level designs and the sck/dout/cs board pins, and replaces single-device, hard-sequenced MAX7219 drivers.

## Interface
- NUM_DEV, 1: number of cascaded MAX7219 devices (1..8).
- CLK_DIV, 4: sck half-period in CLK cycles (≥1).
- DECODE, 8'h00: value written to register 0x09 (decode mode) on every device.
- SCAN_LIMIT, 3'd7: value written to register 0x0B.
- DW = max(1, clog2(NUM_DEV)): local width of the device index.

Ports:
- CLK  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  frame-buffer write strobe.
- wr_dev  in  DW  device index; 0 is the device nearest dout.
- wr_digit  in  3  digit 0..7, sent as register address wr_digit+1.
- wr_data  in  8  segment byte.
- update  in  1  pulse: request a full refresh of all 8 digits.
- intensity  in  4  brightness, sampled when an intensity frame loads.
- set_int  in  1  pulse: request a single intensity frame.
- busy  out  1  high whenever init, refresh or a command is in progress.
- init_done  out  1  high after the init sequence completes; stays high until rst.
- sck  out  1  SPI clock, idle low.
- dout  out  1  SPI data, MSB first.
- cs  out  1  chip select/LOAD, active-low.

## Operation
- Reset, while rst is high and on the following edge: cs=1, sck=0, dout=0, busy=1, init_done=0, all buffer bytes are 0x00, pending flags are cleared, and the controller enters INIT step 0.
- Frame: one cs-low burst of NUM_DEV×16 bits. All devices receive the same address. Device NUM_DEV-1's {addr,data} word is shifted first and device 0's word last. Frame contents load into the shift register at frame start.
- INIT steps, one frame each, in order:
  - 0x0C=00
  - 0x0F=00
  - 0x09=DECODE
  - 0x0B=SCAN_LIMIT
  - 0x0A={4'h0,intensity}
  - 0x0C=01
  - digits 1..8 from the buffer
  
  After the last digit frame: init_done=1, state IDLE.
- Top-level states: INIT, IDLE, REFRESH (digit counter 0..7), INTENS.
- Serializer sub-states: LOAD, LOW, HIGH, TAIL, GAP.
- wr_en is accepted in any state except during rst. A write with wr_dev ≥ NUM_DEV is ignored. The write takes effect on the next edge. A frame already loaded is not affected.
- update and set_int set sticky pending flags in any state.
- Priority in IDLE: update pending → REFRESH (clears the flag at entry), then set_int pending → INTENS.
- An update that arrives during REFRESH causes exactly one further full refresh.
- busy = (state≠IDLE) or a pending flag is set.

## Timing
- Bit cell is 2×CLK_DIV cycles: sck low for CLK_DIV cycles, then high for CLK_DIV cycles. dout changes only while sck is low; it is set on the LOW entry edge.
- cs falls on the LOAD→LOW edge, with dout already carrying the first bit.
- After the last high phase, TAIL holds sck=0 and cs=0 for CLK_DIV cycles; then cs rises.
- cs-low duration per frame = (32×NUM_DEV+1)×CLK_DIV cycles.
- GAP holds cs high for 2×CLK_DIV cycles before the next LOAD. LOAD takes 1 cycle.
- Frame period = (32×NUM_DEV+3)×CLK_DIV+1 cycles.
- IDLE with update asserted → cs falls 2 cycles later (IDLE→LOAD, LOAD→LOW).
- busy deasserts on the edge that returns the controller to IDLE with no pending flag.
- If rst rises mid-frame, cs=1 and sck=0 on the next edge, the frame is abandoned and INIT restarts.

## Test plan
- NUM_DEV=2, CLK_DIV=2, release rst → first frame shifts 32'h0C00_0C00 MSB first; cs stays low for 130 cycles; 14 frames in total, then init_done=1 and busy=0.
- After init, write dev1/digit3=0x4F and dev0/digit3=0x3D, then pulse update → frame 4 carries 32'h044F_043D; the other digit frames carry 0x00 data bytes.
- Pulse update during frame 2 of a refresh → exactly 16 digit frames go out, then busy=0.
- intensity=4'hA, pulse set_int in IDLE → one frame 32'h0A0A_0A0A, then IDLE.
- NUM_DEV=3, write with wr_dev=3 → no buffer change; the following refresh shows all-zero data.
- Assert rst for 1 cycle mid-frame → cs=1 and sck=0 on the next edge; the INIT sequence restarts from 0x0C=00 and the buffer is cleared.
